instr_sequencer: RTL and testbench

Issuing-side counterpart of the `cpu` top-level's instruction handshake. Holds a small program buffer of 16-bit instructions and feeds them one at a time into the CPU: `in`+`load`, then a one-cycle `s` pulse, then it waits for the CPU's `w` to drop and rise again. On completion it captures the CPU's `out` and N/V/Z flags. It sits between the board/test harness and `cpu`, replacing hand-driven `s`/`load` switches, and adds a watchdog so a hung CPU is reported instead of stalling forever.

---
 rtl/instr_seq_pkg.sv | 23 ++
 rtl/prog_buf.sv | 26 ++
 rtl/instr_sequencer.sv | 158 +++++++++++++++
 tb/tb_instr_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and widths for the instruction sequencer.
package instr_seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned NVZ_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDY,
        S_LOAD,
        S_START,
        S_ACK,
        S_FIN,
        S_DONE,
        S_ERR
    } state_e;

    // States in which the sequencer accepts program writes and a new run.
    function automatic logic is_idle(input state_e s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/prog_buf.sv
// Program buffer: synchronous write, asynchronous read, contents survive reset.
module prog_buf
    import instr_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata_c
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds buffered instructions into the CPU via load/s/w handshake, captures
// results, and reports a hung CPU through a per-state watchdog.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               run,
    input  logic [AW:0]        prog_len,
    output logic [INSTR_W-1:0] cpu_in,
    output logic               cpu_load,
    output logic               cpu_s,
    input  logic               cpu_w,
    input  logic [INSTR_W-1:0] cpu_out,
    input  logic [NVZ_W-1:0]   cpu_nvz,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AW-1:0]      pc,
    output logic [INSTR_W-1:0] last_out,
    output logic [NVZ_W-1:0]   last_nvz
);

    localparam int unsigned LW  = AW + 1;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    state_e             state;
    logic [LW-1:0]      len;
    logic [WDW-1:0]     wd;

    logic               idle_c;
    logic               waiting_c;
    logic               wd_exp_c;
    logic               last_c;
    logic [AW-1:0]      rd_addr_c;
    logic [INSTR_W-1:0] rd_word_c;

    // Status decode; FIN pre-reads the next word so LOAD presents it immediately.
    always_comb begin
        idle_c    = is_idle(state);
        waiting_c = ((state == S_RDY) && !cpu_w) ||
                    ((state == S_ACK) &&  cpu_w) ||
                    ((state == S_FIN) && !cpu_w);
        wd_exp_c  = (wd == WDW'(TIMEOUT - 1));
        last_c    = ({1'b0, pc} == (len - LW'(1)));
        rd_addr_c = (state == S_FIN) ? (pc + AW'(1)) : pc;
    end

    prog_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_buf (
        .clk     (clk),
        .we      (prog_we && idle_c),
        .waddr   (prog_addr),
        .wdata   (prog_data),
        .raddr   (rd_addr_c),
        .rdata_c (rd_word_c)
    );

    // Sequencer FSM; outputs are set on entry to the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            len      <= '0;
            wd       <= '0;
            pc       <= '0;
            cpu_in   <= '0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            last_out <= '0;
            last_nvz <= '0;
        end else begin
            done     <= 1'b0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;

            if (waiting_c) begin
                // Stuck waiting on the CPU: the TIMEOUT-th stalled cycle trips the watchdog.
                if (wd_exp_c) begin
                    state <= S_ERR;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    wd    <= '0;
                end else begin
                    wd <= wd + WDW'(1);
                end
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (run) begin
                            len <= prog_len;
                            pc  <= '0;
                            err <= 1'b0;
                            wd  <= '0;
                            if (prog_len == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_RDY;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    S_RDY: begin
                        state    <= S_LOAD;
                        cpu_in   <= rd_word_c;
                        cpu_load <= 1'b1;
                        wd       <= '0;
                    end
                    S_LOAD: begin
                        state <= S_START;
                        cpu_s <= 1'b1;
                    end
                    S_START: begin
                        state <= S_ACK;
                        wd    <= '0;
                    end
                    S_ACK: begin
                        state <= S_FIN;
                        wd    <= '0;
                    end
                    S_FIN: begin
                        last_out <= cpu_out;
                        last_nvz <= cpu_nvz;
                        wd       <= '0;
                        if (last_c) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_LOAD;
                            pc       <= pc + AW'(1);
                            cpu_in   <= rd_word_c;
                            cpu_load <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: behavioral CPU model, issue scoreboard, table-driven runs
// plus watchdog, reset-mid-instruction and write-while-busy sequences.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        run;
    logic [4:0]  prog_len;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic        cpu_w;
    logic [15:0] cpu_out;
    logic [2:0]  cpu_nvz;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  pc;
    logic [15:0] last_out;
    logic [2:0]  last_nvz;

    instr_sequencer #(
        .DEPTH   (16),
        .AW      (4),
        .TIMEOUT (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .run       (run),
        .prog_len  (prog_len),
        .cpu_in    (cpu_in),
        .cpu_load  (cpu_load),
        .cpu_s     (cpu_s),
        .cpu_w     (cpu_w),
        .cpu_out   (cpu_out),
        .cpu_nvz   (cpu_nvz),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc),
        .last_out  (last_out),
        .last_nvz  (last_nvz)
    );

    always #5 clk = ~clk;

    // Toy CPU result: byte-swapped word plus 3, flags from top and bottom bits.
    function automatic logic [18:0] cpu_func(input logic [15:0] w);
        return {w[15:13] ^ w[2:0], {w[7:0], w[15:8]} + 16'h0003};
    endfunction

    int          cpu_lat  = 0;
    bit          cpu_hang = 1'b0;
    int          cpu_cnt;
    logic [15:0] cpu_ir;

    // Behavioral CPU: drop w the cycle after s, raise it again after cpu_lat cycles.
    always @(posedge clk) begin
        if (!reset) begin
            cpu_w   <= 1'b1;
            cpu_cnt <= 0;
            cpu_ir  <= '0;
            cpu_out <= '0;
            cpu_nvz <= '0;
        end else begin
            if (cpu_load) cpu_ir <= cpu_in;
            if (cpu_s) begin
                if (!cpu_hang) begin
                    cpu_w   <= 1'b0;
                    cpu_cnt <= cpu_lat;
                end
            end else if (!cpu_w) begin
                if (cpu_cnt == 0) begin
                    cpu_w              <= 1'b1;
                    {cpu_nvz, cpu_out} <= cpu_func(cpu_ir);
                end else begin
                    cpu_cnt <= cpu_cnt - 1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  pc;
        logic [15:0] word;
    } issue_t;

    issue_t      sb[$];
    logic [15:0] mem [16];
    logic [15:0] exp_last_out = '0;
    logic [2:0]  exp_last_nvz = '0;
    int          s_cnt    = 0;
    int          load_cnt = 0;
    int          done_cnt = 0;

    // Issue monitor: every s pulse must carry the next expected word and pc.
    always @(negedge clk) begin
        issue_t e;
        if (cpu_s === 1'b1) begin
            s_cnt++;
            check("issue_queue_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("issue_word", cpu_in, e.word);
                check("issue_pc", pc, e.pc);
            end
        end
        if (cpu_load === 1'b1) load_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        mem[a]    = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input int len, input int lat, input logic [3:0] exp_pc,
                            input bit poke, input bit wr0, input logic [15:0] wr0_data);
        int          s0, l0, d0;
        bit          seen;
        logic [18:0] r;
        cpu_lat = lat;
        s0 = s_cnt;
        l0 = load_cnt;
        d0 = done_cnt;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = wr0_data;
            mem[0]    = wr0_data;
        end
        for (int i = 0; i < len; i++) sb.push_back('{pc: 4'(i), word: mem[i]});
        prog_len = 5'(len);
        run      = 1'b1;
        @(negedge clk);
        run     = 1'b0;
        prog_we = 1'b0;
        check("err_cleared_by_run", err, 0);
        if (len == 0) begin
            check("done_zero_len", done, 1);
            check("busy_zero_len", busy, 0);
        end else begin
            check("busy_after_run", busy, 1);
            check("load_not_yet", cpu_load, 0);
            if (poke) begin
                prog_we   = 1'b1;
                prog_addr = 4'd1;
                prog_data = 16'hFFFF;
            end
            @(negedge clk);
            prog_we = 1'b0;
            check("run_to_load_2cyc", cpu_load, 1);
            seen = 1'b0;
            for (int k = 0; k < 2000 && !seen; k++) begin
                if (done) seen = 1'b1;
                else @(negedge clk);
            end
            check("done_seen", seen, 1);
            r = cpu_func(mem[len-1]);
            exp_last_out = r[15:0];
            exp_last_nvz = r[18:16];
        end
        @(negedge clk);
        @(negedge clk);
        check("done_single_pulse", 64'(done_cnt - d0), 1);
        check("done_low_after", done, 0);
        check("s_pulses", 64'(s_cnt - s0), 64'(len));
        check("load_pulses", 64'(load_cnt - l0), 64'(len));
        check("final_pc", pc, exp_pc);
        check("busy_final", busy, 0);
        check("last_out", last_out, exp_last_out);
        check("last_nvz", last_nvz, exp_last_nvz);
    endtask

    typedef struct {
        int          len;
        int          lat;
        logic [15:0] base;
        logic [15:0] step;
        logic [3:0]  exp_pc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit seen;
        int k2;

        vecs[0] = '{len: 1,  lat: 0, base: 16'h1234, step: 16'h1111, exp_pc: 4'd0};
        vecs[1] = '{len: 0,  lat: 1, base: 16'h0F0F, step: 16'h0001, exp_pc: 4'd0};
        vecs[2] = '{len: 5,  lat: 3, base: 16'h8001, step: 16'h0203, exp_pc: 4'd4};
        vecs[3] = '{len: 16, lat: 1, base: 16'h0100, step: 16'h0101, exp_pc: 4'd15};
        vecs[4] = '{len: 7,  lat: 6, base: 16'hFFF0, step: 16'h0013, exp_pc: 4'd6};
        vecs[5] = '{len: 2,  lat: 0, base: 16'h4C3B, step: 16'h7777, exp_pc: 4'd1};

        reset     = 1'b0;
        run       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({cpu_in, cpu_load, cpu_s, busy, done, err, pc, last_out, last_nvz}), 0);
        reset = 1'b1;
        @(negedge clk);

        // Reference three-instruction program.
        write_word(4'd0, 16'hD105);
        write_word(4'd1, 16'hD203);
        write_word(4'd2, 16'hA0C1);
        run_prog(3, 2, 4'd2, 1'b0, 1'b0, 16'h0);

        foreach (vecs[v]) begin
            for (int i = 0; i < 16; i++) write_word(4'(i), 16'(vecs[v].base + 16'(i) * vecs[v].step));
            run_prog(vecs[v].len, vecs[v].lat, vecs[v].exp_pc, 1'b0, 1'b0, 16'h0);
        end

        // Write to addr 1 while busy must be ignored.
        run_prog(3, 4, 4'd2, 1'b1, 1'b0, 16'h0);
        // Write and run in the same cycle: run sees the new word.
        run_prog(2, 1, 4'd1, 1'b0, 1'b1, 16'hBEEF);

        // Watchdog: CPU never drops w after s.
        cpu_hang = 1'b1;
        sb.push_back('{pc: 4'd0, word: mem[0]});
        prog_len = 5'd2;
        run      = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (cpu_s) seen = 1'b1;
            else @(negedge clk);
        end
        check("wd_s_seen", seen, 1);
        k2 = 0;
        do begin
            @(negedge clk);
            k2++;
        end while (!err && k2 < 40);
        check("wd_latency", 64'(k2), 11);
        check("wd_err", err, 1);
        check("wd_pc", pc, 0);
        check("wd_busy", busy, 0);
        check("wd_last_out", last_out, exp_last_out);
        check("wd_last_nvz", last_nvz, exp_last_nvz);
        repeat (3) @(negedge clk);
        check("wd_err_held", err, 1);
        cpu_hang = 1'b0;

        // Recovery run from ERR clears err.
        run_prog(3, 2, 4'd2, 1'b0, 1'b0, 16'h0);

        // Reset asserted during FIN of instruction 1.
        for (int i = 0; i < 3; i++) sb.push_back('{pc: 4'(i), word: mem[i]});
        cpu_lat  = 5;
        prog_len = 5'd3;
        run      = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (cpu_s && pc == 4'd1) seen = 1'b1;
            else @(negedge clk);
        end
        check("rst_instr1_seen", seen, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_fin",
              64'({cpu_in, cpu_load, cpu_s, busy, done, err, pc, last_out, last_nvz}), 0);
        reset = 1'b1;
        sb.delete();
        exp_last_out = '0;
        exp_last_nvz = '0;
        @(negedge clk);
        run_prog(3, 2, 4'd2, 1'b0, 1'b0, 16'h0);

        check("scoreboard_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
